// File: rtl/rd_empty_ctrl.sv
// Read-side pointer / empty-flag controller for the async FIFO.
// Optional level and almost-empty outputs: define ASYNC_FIFO_ALMOST_EMPTY_EN.
module rd_empty_ctrl #(
  parameter int PtrWidth       = 2,
  parameter int NSync          = 2,
  parameter int AlmostEmptyThr = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rd_en,
  input  logic [PtrWidth:0]   i_wr_gray_ptr,
  output logic [PtrWidth-1:0] o_rd_addr,
  output logic [PtrWidth:0]   o_rd_bin_ptr,
  output logic [PtrWidth:0]   o_rd_gray_ptr,
  output logic                o_empty,
  output logic                o_underflow
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
  ,
  output logic [PtrWidth:0]   o_rd_level,
  output logic                o_almost_empty
`endif
);

  logic [NSync-1:0] rst_pipe;
  logic             rst_sync;
  logic [PtrWidth:0] wr_sync [NSync];
  logic [PtrWidth:0] wr_bin_sync;
  logic [PtrWidth:0] rd_bin_next;
  logic              rd_acc;

  function automatic logic [PtrWidth:0] gray2bin(input logic [PtrWidth:0] g);
    logic [PtrWidth:0] b;
    b[PtrWidth] = g[PtrWidth];
    for (int unsigned i = PtrWidth; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  // Reset asserts immediately with rst_n, releases NSync clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[NSync-2:0], 1'b1};
  end

  assign rst_sync = rst_pipe[NSync-1];

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      for (int unsigned i = 0; i < NSync; i++) wr_sync[i] <= '0;
    end else begin
      wr_sync[0] <= i_wr_gray_ptr;
      for (int unsigned i = 1; i < NSync; i++) wr_sync[i] <= wr_sync[i-1];
    end
  end

  assign wr_bin_sync = gray2bin(wr_sync[NSync-1]);
  assign rd_acc      = i_rd_en & ~o_empty;
  assign rd_bin_next = o_rd_bin_ptr + {{PtrWidth{1'b0}}, rd_acc};
  assign o_rd_addr   = o_rd_bin_ptr[PtrWidth-1:0];

  // Empty compares the post-read pointer so a consumed slot never shows as valid.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      o_rd_bin_ptr  <= '0;
      o_rd_gray_ptr <= '0;
      o_empty       <= 1'b1;
      o_underflow   <= 1'b0;
    end else begin
      o_rd_bin_ptr  <= rd_bin_next;
      o_rd_gray_ptr <= rd_bin_next ^ (rd_bin_next >> 1);
      o_empty       <= (rd_bin_next == wr_bin_sync);
      if (i_rd_en && o_empty) o_underflow <= 1'b1;
    end
  end

`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
  localparam logic [PtrWidth:0] AeThr = AlmostEmptyThr[PtrWidth:0];
  logic [PtrWidth:0] level_next;

  assign level_next = wr_bin_sync - rd_bin_next;

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      o_rd_level     <= '0;
      o_almost_empty <= 1'b1;
    end else begin
      o_rd_level     <= level_next;
      o_almost_empty <= (level_next <= AeThr);
    end
  end
`endif

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Randomized bench for rd_empty_ctrl against an integer-count FIFO model.
// Level checks are active when ASYNC_FIFO_ALMOST_EMPTY_EN is defined.
module tb_rd_empty_ctrl;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [PW:0]   wr_gray = '0;
  logic [PW-1:0] rd_addr;
  logic [PW:0]   rd_bin;
  logic [PW:0]   rd_gray;
  logic          empty;
  logic          underflow;
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
  logic [PW:0]   rd_level;
  logic          almost_empty;
`endif

  rd_empty_ctrl #(.PtrWidth(PW), .NSync(2), .AlmostEmptyThr(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rd_en       (rd_en),
    .i_wr_gray_ptr (wr_gray),
    .o_rd_addr     (rd_addr),
    .o_rd_bin_ptr  (rd_bin),
    .o_rd_gray_ptr (rd_gray),
    .o_empty       (empty),
    .o_underflow   (underflow)
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
    ,
    .o_rd_level    (rd_level),
    .o_almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: unbounded read/write counts; write count seen two edges late.
  int m_rd, m_h1, m_h2, m_level;
  bit m_empty, m_under;
  int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    check("rd_bin",    int'(rd_bin),    m_rd % 8);
    check("rd_gray",   int'(rd_gray),   gray_tab[m_rd % 8]);
    check("rd_addr",   int'(rd_addr),   m_rd % 4);
    check("empty",     int'(empty),     int'(m_empty));
    check("underflow", int'(underflow), int'(m_under));
`ifdef ASYNC_FIFO_ALMOST_EMPTY_EN
    check("rd_level",     int'(rd_level),     m_level);
    check("almost_empty", int'(almost_empty), int'(m_level <= 1));
`endif
  endtask

  task automatic model_reset();
    m_rd = 0; m_h1 = 0; m_h2 = 0; m_level = 0;
    m_empty = 1'b1; m_under = 1'b0;
  endtask

  // Check the state left by the previous edge, then apply inputs for the next.
  task automatic cycle(input bit ren, input int w);
    @(negedge clk);
    check_all();
    rd_en   = ren;
    wr_gray = 3'(gray_tab[w % 8]);
    if (ren && m_empty) m_under = 1'b1;
    if (ren && !m_empty) m_rd++;
    m_level = m_h2 - m_rd;
    m_empty = (m_level == 0);
    m_h2 = m_h1;
    m_h1 = w;
  endtask

  initial begin
    int  w;
    bit  did_reset;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(0, 0);
    cycle(0, 0);
    repeat (2) cycle(0, 0);

    // Single entry, then one read, then underflow persistence.
    w = 1;
    repeat (4) cycle(0, w);
    cycle(1, w);
    cycle(0, w);
    cycle(1, w);
    repeat (12) cycle(0, w);

    // Wrap-around: write steps to 9 while reading every cycle.
    repeat (20) begin
      if (w < 9) w++;
      cycle(1, w);
    end

    // Fill to four entries, then drain three.
    repeat (4) begin
      w++;
      cycle(0, w);
    end
    repeat (4) cycle(0, w);
    repeat (3) cycle(1, w);
    repeat (4) cycle(0, w);

    did_reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit ren;
      ren = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && (w + 1 - m_rd) <= 4) w++;
      cycle(ren, w);
      if (!did_reset && i > 100 && (m_rd % 8) == 5) begin
        did_reset = 1'b1;
        @(posedge clk);
        #2;
        check_all();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        w = 0;
        rd_en = 1'b0;
        wr_gray = '0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycle(0, 0);
        cycle(0, 0);
      end
    end
    check("mid_reset_done", int'(did_reset), 1);

    @(negedge clk);
    check_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rd_empty_ctrl.md
# rd_empty_ctrl

Read-side pointer and empty-flag controller for the async FIFO, the read-domain counterpart of the write-side full-flag logic. It owns the read binary/Gray pointers and the RAM read address. It synchronizes the write Gray pointer into the read clock domain and produces a registered, never-overread `o_empty` plus a sticky underflow flag. It sits between the FIFO storage (read port) and the read-domain consumer.

## Interface
- `PtrWidth`, 2: address bits; FIFO depth = 2^PtrWidth; pointers are PtrWidth+1 bits.
- `NSync`, 2: flop stages in the write-pointer synchronizer and in the reset synchronizer; minimum 2.
- `AlmostEmptyThr`, 1: almost-empty threshold in entries; only used with `ASYNC_FIFO_ALMOST_EMPTY_EN`.
- `clk` in 1: read-domain clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_rd_en` in 1: read request from consumer.
- `i_wr_gray_ptr` in PtrWidth+1: write Gray pointer, unsynchronized, from write domain.
- `o_rd_addr` out PtrWidth: RAM read address = `o_rd_bin_ptr[PtrWidth-1:0]`.
- `o_rd_bin_ptr` out PtrWidth+1: registered binary read pointer.
- `o_rd_gray_ptr` out PtrWidth+1: registered Gray read pointer, to the write-domain synchronizer.
- `o_empty` out 1: FIFO empty, registered.
- `o_underflow` out 1: sticky, set by a read attempt while empty.
- `o_rd_level` out PtrWidth+1: entries available (macro only).
- `o_almost_empty` out 1: level <= AlmostEmptyThr (macro only).

## Operation
- Reset synchronizer: NSync flops with input tied to 1. Reset asserts asynchronously with `rst_n` and deasserts after NSync rising edges of `clk`. All other state is reset by the synchronized reset.
- Write-pointer sync: NSync-flop chain on `i_wr_gray_ptr`, reset to 0. The output is converted Gray→binary (`wr_bin_sync`) combinationally.
- Read accept: `rd_acc = i_rd_en & ~o_empty`.
- Next binary pointer: `rd_bin_next = o_rd_bin_ptr + rd_acc`, modulo 2^(PtrWidth+1). Wrap from all-ones to 0 is natural; the MSB toggles each lap.
- Registered updates each edge:
  - `o_rd_bin_ptr <= rd_bin_next`
  - `o_rd_gray_ptr <= rd_bin_next ^ (rd_bin_next >> 1)`
  - `o_empty <= (rd_bin_next == wr_bin_sync)`, a full-width compare including the MSB.
- Empty is evaluated against the next pointer, so the consumer never sees `o_empty=0` for a slot already consumed.
- Underflow: `i_rd_en & o_empty` sets `o_underflow <= 1`. The bit stays set until reset. The pointer does not move.
- Ptr states: no FSM beyond the pointer counter. Behaviour is fully set by the pointer, the synced pointer, and the flags.
- Reset values: all pointers 0, `o_rd_addr` 0, `o_empty` 1, `o_underflow` 0, `o_rd_level` 0, `o_almost_empty` 1.
- Reset mid-operation: all outputs return to their reset values asynchronously. Any read in flight is discarded. The write side must be reset at the same time.

## Timing
- Read handshake: with `i_rd_en=1` and `o_empty=0` at an edge, the read is accepted. `o_rd_addr` for the accepted entry is the value before that edge. The pointer advances at that edge.
- Write visibility: a change on `i_wr_gray_ptr` reaches `o_empty` / `o_rd_level` after NSync+1 rising edges (NSync sync stages plus the flag register).
- Read-to-flag latency: `o_empty` reflects an accepted read at the same edge (0 extra cycles).
- `o_rd_gray_ptr` changes by exactly one bit per accepted read. It is glitch-free because it is registered.
- Simultaneous read and synced-pointer change in one cycle: `o_empty` uses both new values.

## Configuration
- Macro: `ASYNC_FIFO_ALMOST_EMPTY_EN`.
- Defined:
  - `o_rd_level <= wr_bin_sync - rd_bin_next`, modulo 2^(PtrWidth+1), range 0..2^PtrWidth.
  - `o_almost_empty <= (that level <= AlmostEmptyThr)`.
  - Both are registered with the same latency as `o_empty`.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset: `rst_n=0`, then release. Required response: `o_empty=1`, `o_underflow=0`, pointers 0 throughout. Flags first updated on the 3rd edge after release (NSync=2).
- Single entry: drive `i_wr_gray_ptr` 0→1. Required response: `o_empty` falls 3 edges later. One `i_rd_en` pulse → `o_rd_bin_ptr=1`, `o_rd_gray_ptr=1`, `o_empty=1` on the same edge.
- Wrap-around (PtrWidth=2): write pointer stepped in Gray through 0..9, read on every non-empty cycle. Required response: `o_rd_bin_ptr` wraps 7→0 and `o_rd_gray_ptr` follows 0,1,3,2,6,7,5,4,0. `o_rd_addr` cycles 0..3. No read is ever accepted with `o_empty=1`.
- Underflow: `i_rd_en=1` while empty. Required response: `o_underflow=1` next edge and it stays 1 for 10+ cycles. Pointer unchanged.
- Full FIFO (write Gray of 4 = 6): `o_rd_level=4` and `o_almost_empty=0`. After 3 reads: `o_rd_level=1`, `o_almost_empty=1` (macro on, AlmostEmptyThr=1).
- Mid-operation reset: assert `rst_n` with `o_rd_bin_ptr=5`. Required response: outputs reach reset values with no clock edge. Normal operation resumes after release.
